itof_pipe: RTL and testbench

Parametrised, fully pipelined integer-to-single-precision converter with valid/ready flow control. It replaces the fixed 32-bit, always-signed, free-running itof in the FPU datapath. It adds a configurable input width, per-transaction signed/unsigned mode, selectable rounding (round-to-nearest-even or toward zero), an inexact flag, a tag passthrough and backpressure. It sits between the integer register read stage and the FPU writeback arbiter.

---
 rtl/fpu_pkg.sv | 19 +
 rtl/itof_pipe_if.sv | 39 +++
 rtl/itof_pipe_lzc.sv | 20 ++
 rtl/itof_pipe.sv | 133 +++++++++++++
 tb/tb_itof_pipe.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: binary32 constants, the rounding-mode encoding and a field
// struct. Shared by itof_pipe and other FPU blocks.
// Ports: none (package).
package fpu_pkg;

  localparam int BIAS   = 127;
  localparam int FRAC_W = 23;
  localparam int EXP_W  = 8;

  localparam logic RM_RNE = 1'b0;  // round to nearest, ties to even
  localparam logic RM_RTZ = 1'b1;  // round toward zero

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [FRAC_W-1:0] frac;
  } f32_t;

endpackage

// File: rtl/itof_pipe_if.sv
// itof_pipe_if: valid/ready operand and result channels of the
// integer-to-binary32 converter.
// Signals:
//   in_valid/in_ready    operand handshake
//   in_op[IN_W]          integer operand
//   in_signed            1: two's complement, 0: unsigned
//   in_rm                rounding mode (fpu_pkg RM_*)
//   in_tag[TAG_W]        opaque tag carried to out_tag
//   out_valid/out_ready  result handshake
//   out_result[32]       binary32 result
//   out_inexact          result is not the exact integer value
//   out_tag[TAG_W]       tag of the result
// Modports: master = producer/consumer side, slave = converter side.
interface itof_pipe_if #(
  parameter int IN_W  = 32,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_op;
  logic             in_signed;
  logic             in_rm;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic             out_inexact;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_op, in_signed, in_rm, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_inexact, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_signed, in_rm, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_inexact, out_tag
  );
endinterface

// File: rtl/itof_pipe_lzc.sv
// lzc: parametrised leading-zero counter.
// Ports:
//   in_i[W]                  value to scan
//   cnt_o[$clog2(W+1)]       number of leading zeros, W when in_i == 0
module lzc #(
  parameter int W = 32
) (
  input  logic [W-1:0]             in_i,
  output logic [$clog2(W+1)-1:0]   cnt_o
);
  localparam int CW = $clog2(W+1);

  // Ascending scan: the highest set bit is the last one to assign.
  always_comb begin
    cnt_o = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (in_i[i]) cnt_o = CW'(W - 1 - i);
    end
  end
endmodule

// File: rtl/itof_pipe.sv
// itof_pipe: three-stage pipelined integer to binary32 converter with
// valid/ready flow control, signed/unsigned operands, RNE/RTZ rounding,
// inexact flag and tag passthrough.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset, clears all stages and outputs
//   io     itof_pipe_if slave (operand in, result out)
// Stages: 1 abs value, 2 normalise, 3 round/pack (output registers).
module itof_pipe
  import fpu_pkg::*;
#(
  parameter int IN_W  = 32,
  parameter int TAG_W = 4
) (
  input  logic          clk,
  input  logic          reset,
  itof_pipe_if.slave    io
);
  localparam int LZ_W = $clog2(IN_W + 1);

  logic advance;

  // stage 1
  logic             s1_valid_q, s1_sign_q, s1_rm_q;
  logic [IN_W-1:0]  s1_mag_q;
  logic [TAG_W-1:0] s1_tag_q;
  logic             s1_sign_d;
  logic [IN_W-1:0]  s1_mag_d;

  // stage 2
  logic             s2_valid_q, s2_sign_q, s2_rm_q, s2_zero_q;
  logic [IN_W-1:0]  s2_norm_q;
  logic [LZ_W-1:0]  s2_lz_q;
  logic [TAG_W-1:0] s2_tag_q;
  logic [LZ_W-1:0]  s2_lz_d;
  logic [IN_W-1:0]  s2_norm_d;

  // stage 3 / outputs
  logic             out_valid_q, out_inexact_q;
  f32_t             out_result_q;
  logic [TAG_W-1:0] out_tag_q;
  f32_t             out_result_d;
  logic             out_inexact_d;

  assign advance     = ~out_valid_q | io.out_ready;
  assign io.in_ready = advance;

  // The most negative signed value negates to 2^(IN_W-1), which is
  // still representable as an IN_W-bit unsigned magnitude.
  assign s1_sign_d = io.in_signed & io.in_op[IN_W-1];
  assign s1_mag_d  = s1_sign_d ? -io.in_op : io.in_op;

  lzc #(.W(IN_W)) u_lzc (
    .in_i  (s1_mag_q),
    .cnt_o (s2_lz_d)
  );

  assign s2_norm_d = s1_mag_q << s2_lz_d;

  // Padding 26 zeros on the right gives a 24-bit mantissa and a guard bit
  // for any IN_W, and makes sticky zero when IN_W <= 24.
  logic [IN_W+25:0]  ext;
  logic [23:0]       mant;
  logic              guard, sticky, round_up, carry;
  logic [FRAC_W-1:0] frac_r;
  logic [EXP_W-1:0]  exp_r;

  assign ext      = {s2_norm_q, 26'd0};
  assign mant     = ext[IN_W+25 -: 24];
  assign guard    = ext[IN_W+1];
  assign sticky   = |ext[IN_W:0];
  assign round_up = (s2_rm_q != RM_RTZ) & guard & (sticky | mant[0]);
  // An all-ones mantissa rounding up wraps the fraction to zero (1.0)
  // and bumps the exponent.
  assign frac_r   = mant[FRAC_W-1:0] + FRAC_W'(round_up);
  assign carry    = round_up & (&mant);
  assign exp_r    = EXP_W'(BIAS + IN_W - 1) - EXP_W'(s2_lz_q) + EXP_W'(carry);

  always_comb begin
    out_result_d  = '0;
    out_inexact_d = 1'b0;
    if (!s2_zero_q) begin
      out_result_d.sign = s2_sign_q;
      out_result_d.exp  = exp_r;
      out_result_d.frac = frac_r;
      out_inexact_d     = guard | sticky;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q    <= 1'b0;
      s1_sign_q     <= 1'b0;
      s1_rm_q       <= 1'b0;
      s1_mag_q      <= '0;
      s1_tag_q      <= '0;
      s2_valid_q    <= 1'b0;
      s2_sign_q     <= 1'b0;
      s2_rm_q       <= 1'b0;
      s2_zero_q     <= 1'b0;
      s2_norm_q     <= '0;
      s2_lz_q       <= '0;
      s2_tag_q      <= '0;
      out_valid_q   <= 1'b0;
      out_inexact_q <= 1'b0;
      out_result_q  <= '0;
      out_tag_q     <= '0;
    end else if (advance) begin
      s1_valid_q    <= io.in_valid;
      s1_sign_q     <= s1_sign_d;
      s1_rm_q       <= io.in_rm;
      s1_mag_q      <= s1_mag_d;
      s1_tag_q      <= io.in_tag;
      s2_valid_q    <= s1_valid_q;
      s2_sign_q     <= s1_sign_q;
      s2_rm_q       <= s1_rm_q;
      s2_zero_q     <= (s1_mag_q == '0);
      s2_norm_q     <= s2_norm_d;
      s2_lz_q       <= s2_lz_d;
      s2_tag_q      <= s1_tag_q;
      out_valid_q   <= s2_valid_q;
      out_inexact_q <= out_inexact_d;
      out_result_q  <= out_result_d;
      out_tag_q     <= s2_tag_q;
    end
  end

  assign io.out_valid   = out_valid_q;
  assign io.out_result  = out_result_q;
  assign io.out_inexact = out_inexact_q;
  assign io.out_tag     = out_tag_q;

endmodule

// File: tb/tb_itof_pipe.sv
module tb_itof_pipe;
  import fpu_pkg::*;

  typedef struct packed {
    logic [31:0] res;
    logic        inx;
    logic [3:0]  tag;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst32;
  logic rst_rand;
  int   total  = 0;
  int   bad    = 0;
  int   n_done = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Reference conversion: exact magnitude, then keep 24 significant bits
  // and decide rounding from the discarded remainder versus one half ulp.
  // Returns {inexact, binary32}.
  function automatic logic [32:0] ref_cvt(input logic [63:0] op_in, input int w,
                                          input logic sgn, input logic rm);
    logic [63:0] mask, op, mag, kept, rem, half;
    logic neg, inx;
    int p, sh;
    logic [7:0] e;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    op   = op_in & mask;
    neg  = sgn && op[w-1];
    mag  = neg ? ((64'd0 - op) & mask) : op;
    if (mag == 64'd0) return 33'd0;
    p = 0;
    for (int i = 0; i < 64; i++) if (mag[i]) p = i;
    inx = 1'b0;
    if (p <= 23) begin
      kept = mag << (23 - p);
    end else begin
      sh   = p - 23;
      kept = mag >> sh;
      rem  = mag & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      inx  = (rem != 64'd0);
      if (rm == RM_RNE && (rem > half || (rem == half && kept[0]))) kept = kept + 64'd1;
      if (kept == (64'd1 << 24)) begin
        kept = 64'd1 << 23;
        p++;
      end
    end
    e = 8'(BIAS + p);
    return {inx, neg, e, kept[22:0]};
  endfunction

  // ---------------- IN_W = 32 instance: directed tests ----------------
  itof_pipe_if #(.IN_W(32), .TAG_W(4)) bus32();
  itof_pipe #(.IN_W(32), .TAG_W(4)) u_dut32 (.clk(clk), .reset(rst32), .io(bus32.slave));

  exp_t q32[$];
  int   got32  = 0;
  int   bp_low = 0;
  logic bp_win = 1'b0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst32 !== 1'b1 && bus32.out_valid === 1'b1 && bus32.out_ready === 1'b1) begin
        if (q32.size() == 0) begin
          total++;
          bad++;
          $display("FAIL w32 unexpected output: got %h tag %h, required none",
                   bus32.out_result, bus32.out_tag);
        end else begin
          e = q32.pop_front();
          chk($sformatf("w32 result #%0d", got32),
              {27'd0, bus32.out_result, bus32.out_inexact, bus32.out_tag}, {27'd0, e});
        end
        got32++;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (bp_win && bus32.in_ready !== 1'b1) bp_low++;
  end

  task automatic send32(input logic [31:0] op, input logic sgn, input logic rm,
                        input logic [3:0] tag, input logic [31:0] er, input logic ei);
    int t = 0;
    bus32.in_valid  = 1'b1;
    bus32.in_op     = op;
    bus32.in_signed = sgn;
    bus32.in_rm     = rm;
    bus32.in_tag    = tag;
    @(negedge clk);
    while (bus32.in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (bus32.in_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL w32 accept timeout: in_ready=%b required 1", bus32.in_ready);
    end else begin
      q32.push_back({er, ei, tag});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic sendm32(input logic [31:0] op, input logic sgn, input logic rm,
                         input logic [3:0] tag);
    logic [32:0] r;
    r = ref_cvt({32'd0, op}, 32, sgn, rm);
    send32(op, sgn, rm, tag, r[31:0], r[32]);
  endtask

  task automatic drain32(input string name);
    int t = 0;
    bus32.in_valid = 1'b0;
    while (q32.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    chk(name, 64'(q32.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int g0, ov, lat;
    rst32 = 1'b1;
    bus32.in_valid = 1'b0; bus32.in_op = '0; bus32.in_signed = 1'b0;
    bus32.in_rm = 1'b0; bus32.in_tag = '0; bus32.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst32 = 1'b0;
    @(negedge clk);
    chk("reset out_valid", 64'(bus32.out_valid), 64'd0);
    chk("reset in_ready", 64'(bus32.in_ready), 64'd1);
    chk("reset out_result", 64'(bus32.out_result), 64'd0);
    chk("reset out_inexact/tag", 64'({bus32.out_inexact, bus32.out_tag}), 64'd0);
    @(posedge clk);
    #1;

    send32(32'd1,          1'b1, RM_RNE, 4'h1, 32'h3F80_0000, 1'b0);
    send32(32'hFFFF_FFFF,  1'b1, RM_RNE, 4'h2, 32'hBF80_0000, 1'b0);
    send32(32'd0,          1'b1, RM_RNE, 4'h3, 32'h0000_0000, 1'b0);
    send32(32'h8000_0000,  1'b1, RM_RNE, 4'h4, 32'hCF00_0000, 1'b0);
    send32(32'h7FFF_FFFF,  1'b1, RM_RNE, 4'h5, 32'h4F00_0000, 1'b1);
    send32(32'h7FFF_FFFF,  1'b1, RM_RTZ, 4'h6, 32'h4EFF_FFFF, 1'b1);
    send32(32'd16777217,   1'b1, RM_RNE, 4'h7, 32'h4B80_0000, 1'b1);
    send32(32'd16777219,   1'b1, RM_RNE, 4'h8, 32'h4B80_0002, 1'b1);
    send32(32'hFFFF_FFFF,  1'b0, RM_RNE, 4'h9, 32'h4F80_0000, 1'b1);
    send32(32'hFFFF_FFFF,  1'b1, RM_RTZ, 4'hA, 32'hBF80_0000, 1'b0);
    drain32("w32 directed drained");

    // Back-to-back stream of 8 with a 5-cycle output stall mid-stream.
    g0     = got32;
    bp_low = 0;
    bp_win = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++)
          sendm32($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'(i));
        bus32.in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1 bus32.out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 bus32.out_ready = 1'b1;
      end
    join
    drain32("w32 stream drained");
    bp_win = 1'b0;
    chk("w32 stall in_ready low cycles", 64'(bp_low), 64'd5);
    chk("w32 stream results delivered", 64'(got32 - g0), 64'd8);

    // Reset with operands in flight: two in the pipe, a third offered
    // on the reset edge.
    bus32.in_valid = 1'b1; bus32.in_signed = 1'b0; bus32.in_rm = RM_RNE;
    bus32.in_op = 32'd100; bus32.in_tag = 4'hB;
    @(posedge clk); #1;
    bus32.in_op = 32'd200; bus32.in_tag = 4'hC;
    @(posedge clk); #1;
    bus32.in_op = 32'd300; bus32.in_tag = 4'hD;
    rst32 = 1'b1;
    @(posedge clk); #1;
    rst32 = 1'b0;
    bus32.in_valid = 1'b0;
    @(negedge clk);
    chk("mid reset out_valid", 64'(bus32.out_valid), 64'd0);
    chk("mid reset out_result", 64'(bus32.out_result), 64'd0);
    chk("mid reset in_ready", 64'(bus32.in_ready), 64'd1);
    ov = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus32.out_valid === 1'b1) ov++;
    end
    chk("mid reset discarded outputs", 64'(ov), 64'd0);
    @(posedge clk); #1;
    send32(32'd5, 1'b0, RM_RNE, 4'hE, 32'h40A0_0000, 1'b0);
    bus32.in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus32.out_valid !== 1'b1 && lat < 10);
    chk("post reset latency", 64'(lat), 64'd3);
    drain32("w32 post reset drained");
    n_done++;
  end

  // -------------- random configurations IN_W = 8, 24, 64 --------------
  initial begin
    rst_rand = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_rand = 1'b0;
  end

  for (genvar g = 0; g < 3; g++) begin : g_rand
    localparam int W = (g == 0) ? 8 : (g == 1) ? 24 : 64;

    itof_pipe_if #(.IN_W(W), .TAG_W(4)) bus();
    itof_pipe #(.IN_W(W), .TAG_W(4)) u_dut (.clk(clk), .reset(rst_rand), .io(bus.slave));

    exp_t q[$];
    int   got = 0;

    initial begin
      exp_t e;
      forever begin
        @(negedge clk);
        if (rst_rand !== 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL w%0d unexpected output: got %h, required none", W, bus.out_result);
          end else begin
            e = q.pop_front();
            chk($sformatf("w%0d result #%0d", W, got),
                {27'd0, bus.out_result, bus.out_inexact, bus.out_tag}, {27'd0, e});
          end
          got++;
        end
      end
    end

    initial begin
      logic [63:0] r;
      logic [32:0] m;
      logic acc;
      int n, cyc, t;
      n = 0; cyc = 0; t = 0; acc = 1'b0; r = '0;
      bus.in_valid = 1'b0; bus.in_op = '0; bus.in_signed = 1'b0;
      bus.in_rm = 1'b0; bus.in_tag = '0; bus.out_ready = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      while (n < 1000 && cyc < 20000) begin
        cyc++;
        bus.out_ready = ($urandom_range(0, 3) != 0);
        if (bus.in_valid !== 1'b1 || acc) begin
          if ($urandom_range(0, 4) != 0) begin
            r = {$urandom, $urandom} >> $urandom_range(0, 63);
            case ($urandom_range(0, 19))
              0: r = 64'd0;
              1: r = 64'hFFFF_FFFF_FFFF_FFFF;
              2: r = 64'd1 << (W - 1);
              default: ;
            endcase
            bus.in_op     = r[W-1:0];
            bus.in_signed = 1'($urandom_range(0, 1));
            bus.in_rm     = 1'($urandom_range(0, 1));
            bus.in_tag    = 4'($urandom_range(0, 15));
            bus.in_valid  = 1'b1;
          end else begin
            bus.in_valid = 1'b0;
          end
        end
        @(negedge clk);
        acc = (bus.in_valid === 1'b1 && bus.in_ready === 1'b1);
        if (acc) begin
          m = ref_cvt(64'(bus.in_op), W, bus.in_signed, bus.in_rm);
          q.push_back({m[31:0], m[32], bus.in_tag});
          n++;
        end
        @(posedge clk);
        #1;
      end
      if (n < 1000) begin
        total++;
        bad++;
        $display("FAIL w%0d stimulus timeout: accepted %0d required 1000", W, n);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      while (q.size() != 0 && t < 100) begin
        @(posedge clk);
        t++;
      end
      chk($sformatf("w%0d queue drained", W), 64'(q.size()), 64'd0);
      chk($sformatf("w%0d results delivered", W), 64'(got), 64'd1000);
      n_done++;
    end
  end

  initial begin
    wait (n_done == 4);
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: run did not complete, done=%0d required 4", n_done);
    $fatal(1, "watchdog expired");
  end

endmodule
